// File: rtl/pipelined_control_unit.sv
// MIPS main/ALU decoder feeding a D->E->M->W control pipeline.
// D holds on stallD, E takes a bubble on flushE, M and W always advance.
module pipelined_control_unit #(
    parameter int INSTR_W    = 32,
    parameter int ALUCTRL_W  = 4,
    parameter int REG_DECODE = 1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 instrValid,
    input  logic                 stallD,
    input  logic                 flushE,
    output logic                 regWriteD,
    output logic                 memToRegD,
    output logic                 memWriteD,
    output logic                 ALUSrcD,
    output logic                 regDstD,
    output logic                 branchD,
    output logic                 jumpD,
    output logic [1:0]           ALUOpD,
    output logic [ALUCTRL_W-1:0] ALUControlD,
    output logic                 illegalD,
    output logic                 regWriteE,
    output logic                 memToRegE,
    output logic                 memWriteE,
    output logic                 ALUSrcE,
    output logic                 regDstE,
    output logic                 branchE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 regWriteM,
    output logic                 memToRegM,
    output logic                 memWriteM,
    output logic                 regWriteW,
    output logic                 memToRegW,
    output logic [CNT_W-1:0]     illegalCount
);

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 branch;
        logic                 jump;
        logic [1:0]           alu_op;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 illegal;
    } ctrl_t;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);
    localparam logic [ALUCTRL_W-1:0] ALU_BAD = ALUCTRL_W'(4'b1111);

    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic vld);
        ctrl_t c;
        c = '0;
        if (vld) begin
            case (op)
                6'b000000: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = 2'b10; end
                6'b100011: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; end
                6'b101011: begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
                6'b000100: begin c.branch = 1'b1; c.alu_op = 2'b01; end
                6'b001000: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
                6'b000010: c.jump = 1'b1;
                default:   c.illegal = 1'b1;
            endcase
            // Unknown opcodes stay an all-zero word apart from the illegal flag.
            if (!c.illegal) begin
                case (c.alu_op)
                    2'b00:   c.alu_ctrl = ALU_ADD;
                    2'b01:   c.alu_ctrl = ALU_SUB;
                    default: begin
                        case (fn)
                            6'b100000: c.alu_ctrl = ALU_ADD;
                            6'b100010: c.alu_ctrl = ALU_SUB;
                            6'b100100: c.alu_ctrl = ALU_AND;
                            6'b100101: c.alu_ctrl = ALU_OR;
                            6'b101010: c.alu_ctrl = ALU_SLT;
                            default:   begin c.alu_ctrl = ALU_BAD; c.illegal = 1'b1; end
                        endcase
                    end
                endcase
            end
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ctrl_t      dec;
    ctrl_t      d_p0;
    ctrl_t      e_p1;
    logic [2:0] m_p2;
    logic [1:0] w_p3;

    assign dec = decode(instruction[INSTR_W-1 -: 6], instruction[5:0], instrValid);

    // D stage
    generate
        if (REG_DECODE != 0) begin : g_dreg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    d_p0 <= '0;
                else if (!stallD)
                    d_p0 <= dec;
            end
        end else begin : g_dcomb
            assign d_p0 = rst_n ? dec : '0;
        end
    endgenerate

    // E stage and illegal counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_p1         <= '0;
            illegalCount <= '0;
        end else begin
            e_p1 <= flushE ? '0 : d_p0;
            if (!flushE && d_p0.illegal)
                illegalCount <= sat_inc(illegalCount);
        end
    end

    // M and W stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p2 <= '0;
            w_p3 <= '0;
        end else begin
            m_p2 <= {e_p1.mem_write, e_p1.mem_to_reg, e_p1.reg_write};
            w_p3 <= m_p2[1:0];
        end
    end

    assign regWriteD   = d_p0.reg_write;
    assign memToRegD   = d_p0.mem_to_reg;
    assign memWriteD   = d_p0.mem_write;
    assign ALUSrcD     = d_p0.alu_src;
    assign regDstD     = d_p0.reg_dst;
    assign branchD     = d_p0.branch;
    assign jumpD       = d_p0.jump;
    assign ALUOpD      = d_p0.alu_op;
    assign ALUControlD = d_p0.alu_ctrl;
    assign illegalD    = d_p0.illegal;

    assign regWriteE   = e_p1.reg_write;
    assign memToRegE   = e_p1.mem_to_reg;
    assign memWriteE   = e_p1.mem_write;
    assign ALUSrcE     = e_p1.alu_src;
    assign regDstE     = e_p1.reg_dst;
    assign branchE     = e_p1.branch;
    assign ALUControlE = e_p1.alu_ctrl;

    assign {memWriteM, memToRegM, regWriteM} = m_p2;
    assign {memToRegW, regWriteW}            = w_p3;

    logic unused_bits;
    assign unused_bits = ^{instruction[INSTR_W-7:6], e_p1.jump, e_p1.alu_op, e_p1.illegal, stallD};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Randomized bench for pipelined_control_unit against a stage-array reference model.
// A second instance with a 2-bit counter shares the stimulus to cover saturation.
module tb_pipelined_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instrValid;
    logic        stallD;
    logic        flushE;

    logic       regWriteD, memToRegD, memWriteD, ALUSrcD, regDstD, branchD, jumpD, illegalD;
    logic [1:0] ALUOpD;
    logic [3:0] ALUControlD, ALUControlE;
    logic       regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE, branchE;
    logic       regWriteM, memToRegM, memWriteM, regWriteW, memToRegW;
    logic [7:0] illegalCount;

    logic       b_regWriteD, b_memToRegD, b_memWriteD, b_ALUSrcD, b_regDstD, b_branchD, b_jumpD;
    logic       b_illegalD;
    logic [1:0] b_ALUOpD;
    logic [3:0] b_ALUControlD, b_ALUControlE;
    logic       b_regWriteE, b_memToRegE, b_memWriteE, b_ALUSrcE, b_regDstE, b_branchE;
    logic       b_regWriteM, b_memToRegM, b_memWriteM, b_regWriteW, b_memToRegW;
    logic [1:0] b_illegalCount;

    pipelined_control_unit #(.INSTR_W(32), .ALUCTRL_W(4), .REG_DECODE(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .instrValid(instrValid),
        .stallD(stallD), .flushE(flushE),
        .regWriteD(regWriteD), .memToRegD(memToRegD), .memWriteD(memWriteD), .ALUSrcD(ALUSrcD),
        .regDstD(regDstD), .branchD(branchD), .jumpD(jumpD), .ALUOpD(ALUOpD),
        .ALUControlD(ALUControlD), .illegalD(illegalD),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE), .ALUSrcE(ALUSrcE),
        .regDstE(regDstE), .branchE(branchE), .ALUControlE(ALUControlE),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .regWriteW(regWriteW), .memToRegW(memToRegW), .illegalCount(illegalCount)
    );

    pipelined_control_unit #(.INSTR_W(32), .ALUCTRL_W(4), .REG_DECODE(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .instrValid(instrValid),
        .stallD(stallD), .flushE(flushE),
        .regWriteD(b_regWriteD), .memToRegD(b_memToRegD), .memWriteD(b_memWriteD),
        .ALUSrcD(b_ALUSrcD), .regDstD(b_regDstD), .branchD(b_branchD), .jumpD(b_jumpD),
        .ALUOpD(b_ALUOpD), .ALUControlD(b_ALUControlD), .illegalD(b_illegalD),
        .regWriteE(b_regWriteE), .memToRegE(b_memToRegE), .memWriteE(b_memWriteE),
        .ALUSrcE(b_ALUSrcE), .regDstE(b_regDstE), .branchE(b_branchE),
        .ALUControlE(b_ALUControlE),
        .regWriteM(b_regWriteM), .memToRegM(b_memToRegM), .memWriteM(b_memWriteM),
        .regWriteW(b_regWriteW), .memToRegW(b_memToRegW), .illegalCount(b_illegalCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [36:0] all_out;
    logic [30:0] all_out2;
    assign all_out = {regWriteD, memToRegD, memWriteD, ALUSrcD, regDstD, branchD, jumpD,
                      ALUOpD, ALUControlD, illegalD, regWriteE, memToRegE, memWriteE,
                      ALUSrcE, regDstE, branchE, ALUControlE, regWriteM, memToRegM,
                      memWriteM, regWriteW, memToRegW, illegalCount};
    assign all_out2 = {b_regWriteD, b_memToRegD, b_memWriteD, b_ALUSrcD, b_regDstD,
                       b_branchD, b_jumpD, b_ALUOpD, b_ALUControlD, b_illegalD,
                       b_regWriteE, b_memToRegE, b_memWriteE, b_ALUSrcE, b_regDstE,
                       b_branchE, b_ALUControlE, b_regWriteM, b_memToRegM, b_memWriteM,
                       b_regWriteW, b_memToRegW, b_illegalCount};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model word: {illegal, 2'b0, alu_ctrl[3:0], alu_op[1:0], jump, branch, reg_dst,
    //              alu_src, mem_write, mem_to_reg, reg_write}
    function automatic logic [15:0] ref_dec(input logic [31:0] ins, input logic v);
        logic [5:0] op, fn;
        logic       rw, m2r, mwr, as, rd, br, jp, ill;
        logic [1:0] aop;
        logic [3:0] ac;
        op = ins[31:26]; fn = ins[5:0];
        {rw, m2r, mwr, as, rd, br, jp, ill} = '0;
        aop = 2'b00; ac = 4'h0;
        if (!v) return 16'h0000;
        case (op)
            6'h00:   begin rw = 1; rd = 1; aop = 2'b10; end
            6'h23:   begin rw = 1; m2r = 1; as = 1; end
            6'h2b:   begin mwr = 1; as = 1; end
            6'h04:   begin br = 1; aop = 2'b01; end
            6'h08:   begin rw = 1; as = 1; end
            6'h02:   jp = 1;
            default: return 16'h8000;
        endcase
        if (aop == 2'b00)      ac = 4'd2;
        else if (aop == 2'b01) ac = 4'd6;
        else begin
            case (fn)
                6'h20:   ac = 4'd2;
                6'h22:   ac = 4'd6;
                6'h24:   ac = 4'd0;
                6'h25:   ac = 4'd1;
                6'h2a:   ac = 4'd7;
                default: begin ac = 4'hf; ill = 1; end
            endcase
        end
        return {ill, 2'b00, ac, aop, jp, br, rd, as, mwr, m2r, rw};
    endfunction

    logic [15:0] stage [4];   // 0=D 1=E 2=M 3=W
    int cnt8, cnt2;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) stage[i] = 16'h0;
        cnt8 = 0; cnt2 = 0;
    endtask

    task automatic model_edge();
        if (!flushE && stage[0][15]) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3)   cnt2++;
        end
        stage[3] = stage[2];
        stage[2] = stage[1];
        stage[1] = flushE ? 16'h0 : stage[0];
        if (!stallD) stage[0] = ref_dec(instruction, instrValid);
    endtask

    task automatic compare_all();
        check("d_word", {illegalD, 2'b00, ALUControlD, ALUOpD, jumpD, branchD, regDstD,
                         ALUSrcD, memWriteD, memToRegD, regWriteD}, stage[0]);
        check("e_word", {ALUControlE, branchE, regDstE, ALUSrcE, memWriteE, memToRegE,
                         regWriteE}, {stage[1][12:9], stage[1][5:0]});
        check("m_word", {memWriteM, memToRegM, regWriteM}, stage[2][2:0]);
        check("w_word", {memToRegW, regWriteW}, stage[3][1:0]);
        check("count8", illegalCount, cnt8);
        check("count2", b_illegalCount, cnt2);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check("rst_zero", all_out, 37'h0);
        check("rst_zero2", all_out2, 31'h0);
        check("rst_nox", {$isunknown(all_out), $isunknown(all_out2)}, 2'b00);
        model_clear();
        #2 rst_n = 1'b1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        instruction = ins; instrValid = v; stallD = st; flushE = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  op, fn;
        r = $urandom;
        case ($urandom_range(0, 7))
            0, 1: op = 6'h00;
            2:    op = 6'h23;
            3:    op = 6'h2b;
            4:    op = 6'h04;
            5:    op = 6'h08;
            6:    op = 6'h02;
            default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 6))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2a;
            default: fn = 6'($urandom);
        endcase
        return {op, r[25:6], fn};
    endfunction

    initial begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #2;
        check("init_zero", all_out, 37'h0);
        check("init_nox", $isunknown(all_out), 1'b0);
        #2 rst_n = 1'b1;

        // add: D decode, E one edge later, W four edges after presentation
        drive(32'h00430820, 1'b1, 1'b0, 1'b0);
        step();
        check("add_d", {ALUControlD, ALUOpD, regDstD, regWriteD}, {4'b0010, 2'b10, 1'b1, 1'b1});
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("add_e", {regWriteE, regDstE, ALUControlE}, {1'b1, 1'b1, 4'b0010});
        step(); step();
        check("add_w", regWriteW, 1'b1);

        // lw then sw
        drive(32'h8c220004, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'hac230008, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        step(); step();
        check("lw_w", memToRegW, 1'b1);
        check("sw_m", memWriteM, 1'b1);

        // lw held in D with E bubbled for two edges
        drive(32'h8c220004, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h00430820, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_d", {illegalD, 2'b00, ALUControlD, ALUOpD, jumpD, branchD, regDstD,
                              ALUSrcD, memWriteD, memToRegD, regWriteD}, 16'h040B);
            check("stall_e", {regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE, branchE,
                              ALUControlE}, 10'h0);
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("stall_rel", {regWriteE, memToRegE, ALUSrcE}, 3'b111);

        // illegal counting after a mid-run reset
        reset_mid();
        drive(32'hfc000000, 1'b1, 1'b0, 1'b0);
        step();
        check("ill_op", illegalD, 1'b1);
        drive(32'h00000007, 1'b1, 1'b0, 1'b0);
        step();
        check("ill_fn", illegalD, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("ill_cnt", illegalCount, 8'd2);
        drive(32'hfc000000, 1'b1, 1'b0, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("ill_flush", illegalCount, 8'd2);

        // saturation of the narrow counter, then beq
        drive(32'hfc000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        check("sat8", illegalCount, 8'd7);
        check("sat2", b_illegalCount, 2'd3);
        drive(32'h10220003, 1'b1, 1'b0, 1'b0);
        step(); step();
        check("beq_e", {branchE, ALUControlE}, {1'b1, 4'b0110});

        // randomized traffic with occasional mid-run resets
        for (int n = 0; n < 600; n++) begin
            drive(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 99) == 0) reset_mid();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
